qpsk_bit_splitter: RTL

- Upstream feeder for the QPSK mixer stage.
- Accepts a serial bitstream over a valid/ready handshake and pairs consecutive bits into dibits: first bit is I, second bit is Q.
- Buffers pairs in a small FIFO.
- Presents each dibit on Ichannel/Qchannel, held stable for exactly SYM_LEN clocks so the mixer sees whole carrier periods per symbol.

---
 rtl/qpsk_bit_splitter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/qpsk_bit_splitter.sv
// Serial bit -> dibit splitter feeding the QPSK mixer; one dibit per SYM_LEN clocks.
// Define DQPSK_EN to apply differential phase encoding at FIFO pop.
module qpsk_bit_splitter #(
    parameter int SYM_LEN    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_in,
    input  logic bit_valid,
    output logic bit_ready,
    output logic Ichannel,
    output logic Qchannel,
    output logic sym_strobe,
    output logic active,
    output logic underflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 1;
    localparam int CW = $clog2(SYM_LEN);

    typedef enum logic {IDLE, RUN} state_t;

    logic [1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [NW-1:0] count;
    logic          phase;
    logic          i_hold;
    logic          accept;
    logic          wr;
    logic          load;
    logic          uf_nxt;
    logic          sym_end;
    logic          fifo_empty;
    logic [1:0]    pop_data;
    logic [1:0]    sym;
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    assign bit_ready  = (count < NW'(FIFO_DEPTH));
    assign accept     = bit_valid && bit_ready;
    assign wr         = accept && phase;
    assign fifo_empty = (count == '0);
    assign sym_end    = (cnt == CW'(SYM_LEN - 1));

    // An empty FIFO at symbol end can still pop the pair completing this edge.
    assign pop_data = fifo_empty ? {i_hold, bit_in} : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            phase  <= 1'b0;
            i_hold <= 1'b0;
        end else begin
            if (accept) begin
                if (!phase)
                    i_hold <= bit_in;
                phase <= ~phase;
            end
            if (wr)
                wr_ptr <= wr_ptr + AW'(1);
            if (load)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + NW'(wr) - NW'(load);
        end
    end

    always_ff @(posedge clk) begin
        if (wr)
            mem[wr_ptr] <= {i_hold, bit_in};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (!fifo_empty) state_nxt = RUN;
            RUN:  if (sym_end && fifo_empty && !wr) state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load    = 1'b0;
        uf_nxt  = 1'b0;
        cnt_nxt = cnt;
        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                load    = !fifo_empty;
            end
            RUN: begin
                if (!sym_end) begin
                    cnt_nxt = cnt + CW'(1);
                end else begin
                    cnt_nxt = '0;
                    load    = !fifo_empty || wr;
                    uf_nxt  = fifo_empty && !wr;
                end
            end
        endcase
    end

`ifdef DQPSK_EN
    logic [1:0] p;
    logic [1:0] p_nxt;
    logic [1:0] inc;

    always_comb begin
        inc = 2'd0;
        unique case (pop_data)
            2'b00: inc = 2'd0;
            2'b01: inc = 2'd1;
            2'b11: inc = 2'd2;
            2'b10: inc = 2'd3;
        endcase
        p_nxt = p + inc;
        sym   = 2'b11;
        unique case (p_nxt)
            2'd0: sym = 2'b11;
            2'd1: sym = 2'b01;
            2'd2: sym = 2'b00;
            2'd3: sym = 2'b10;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            p <= 2'd0;
        else if (load)
            p <= p_nxt;
    end
`else
    assign sym = pop_data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Ichannel   <= 1'b0;
            Qchannel   <= 1'b0;
            sym_strobe <= 1'b0;
            active     <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (load)
                {Ichannel, Qchannel} <= sym;
            sym_strobe <= load;
            active     <= (state_nxt == RUN);
            underflow  <= uf_nxt;
        end
    end

endmodule
